// File: rtl/stage_decode.sv
// stage_decode: RV32I decode stage between fetch and execute with a registered valid/ready output.
// Define DECODE_SKID_BUFFER_EN to add one skid entry and make fetch_ready_o a flop output.
module stage_decode #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_ir_i,
    input  logic [31:0] fetch_pc_next_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    output logic [31:0] decode_pc_o,
    output logic [31:0] decode_pc_next_o,
    output logic [31:0] decode_ir_o,
    output logic [4:0]  decode_rs1_o,
    output logic [4:0]  decode_rs2_o,
    output logic [4:0]  decode_rd_o,
    output logic [31:0] decode_imm_o,
    output logic [2:0]  decode_fmt_o,
    output logic        decode_illegal_o,
    output logic        decode_valid_o,
    input  logic        decode_ready_i,
    output logic [31:0] decode_count_o
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LOAD   = 7'b0000011,
        OP_OPIMM  = 7'b0010011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_OP     = 7'b0110011
    } opcode_e;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_pc_next;
    logic [31:0] r_ir;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_imm;
    fmt_e        r_fmt;
    logic        r_illegal;
    logic [31:0] r_count;

    logic [31:0] w_src_pc;
    logic [31:0] w_src_pc_next;
    logic [31:0] w_src_ir;
    logic        w_have_src;
    logic        w_fetch_fire;
    logic        w_out_fire;
    logic        w_out_load;

    fmt_e        w_fmt;
    logic        w_illegal;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;

    assign w_fetch_fire = fetch_valid_i && fetch_ready_o;
    assign w_out_fire   = r_valid && decode_ready_i;
    assign w_out_load   = !r_valid || decode_ready_i;

`ifdef DECODE_SKID_BUFFER_EN
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_pc_next;
    logic [31:0] r_skid_ir;
    logic        r_fetch_ready;
    logic        w_skid_valid_next;

    // The skid entry is always older than anything on the fetch port, so it feeds the output first.
    assign w_src_pc      = r_skid_valid ? r_skid_pc      : fetch_pc_i;
    assign w_src_pc_next = r_skid_valid ? r_skid_pc_next : fetch_pc_next_i;
    assign w_src_ir      = r_skid_valid ? r_skid_ir      : fetch_ir_i;
    assign w_have_src    = r_skid_valid || w_fetch_fire;
    assign fetch_ready_o = r_fetch_ready;

    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (flush_i) begin
            w_skid_valid_next = 1'b0;
        end else if (w_out_load) begin
            w_skid_valid_next = 1'b0;
        end else if (w_fetch_fire) begin
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_skid_valid   <= 1'b0;
            r_skid_pc      <= '0;
            r_skid_pc_next <= '0;
            r_skid_ir      <= '0;
            r_fetch_ready  <= 1'b0;
        end else begin
            r_skid_valid  <= w_skid_valid_next;
            r_fetch_ready <= !w_skid_valid_next;
            if (!flush_i && !w_out_load && w_fetch_fire) begin
                r_skid_pc      <= fetch_pc_i;
                r_skid_pc_next <= fetch_pc_next_i;
                r_skid_ir      <= fetch_ir_i;
            end
        end
    end
`else
    assign w_src_pc      = fetch_pc_i;
    assign w_src_pc_next = fetch_pc_next_i;
    assign w_src_ir      = fetch_ir_i;
    assign w_have_src    = w_fetch_fire;
    assign fetch_ready_o = !rst_i && (!r_valid || decode_ready_i);
`endif

    always_comb begin
        w_fmt     = FMT_ILL;
        w_illegal = 1'b0;
        w_rs1     = '0;
        w_rs2     = '0;
        w_rd      = '0;
        w_imm     = '0;
        case (w_src_ir[6:0])
            OP_LUI, OP_AUIPC: begin
                w_fmt = FMT_U;
                w_rd  = w_src_ir[11:7];
                w_imm = {w_src_ir[31:12], 12'h000};
            end
            OP_JAL: begin
                w_fmt = FMT_J;
                w_rd  = w_src_ir[11:7];
                w_imm = {{11{w_src_ir[31]}}, w_src_ir[31], w_src_ir[19:12],
                         w_src_ir[20], w_src_ir[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE, OP_SYSTEM: begin
                w_fmt = FMT_I;
                w_rd  = w_src_ir[11:7];
                w_rs1 = w_src_ir[19:15];
                w_imm = {{20{w_src_ir[31]}}, w_src_ir[31:20]};
            end
            OP_STORE: begin
                w_fmt = FMT_S;
                w_rs1 = w_src_ir[19:15];
                w_rs2 = w_src_ir[24:20];
                w_imm = {{20{w_src_ir[31]}}, w_src_ir[31:25], w_src_ir[11:7]};
            end
            OP_BRANCH: begin
                w_fmt = FMT_B;
                w_rs1 = w_src_ir[19:15];
                w_rs2 = w_src_ir[24:20];
                w_imm = {{19{w_src_ir[31]}}, w_src_ir[31], w_src_ir[7],
                         w_src_ir[30:25], w_src_ir[11:8], 1'b0};
            end
            OP_OP: begin
                w_fmt = FMT_R;
                w_rd  = w_src_ir[11:7];
                w_rs1 = w_src_ir[19:15];
                w_rs2 = w_src_ir[24:20];
            end
            default: begin
                w_fmt     = FMT_ILL;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Flush wins over both transfers: nothing loads and the hand-off to execute is not counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_VECTOR;
            r_pc_next <= RESET_VECTOR;
            r_ir      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_imm     <= '0;
            r_fmt     <= FMT_R;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else begin
            if (w_out_fire) begin
                r_count <= r_count + 32'd1;
            end
            if (w_out_load) begin
                r_valid <= w_have_src;
                if (w_have_src) begin
                    r_pc      <= w_src_pc;
                    r_pc_next <= w_src_pc_next;
                    r_ir      <= w_src_ir;
                    r_rs1     <= w_rs1;
                    r_rs2     <= w_rs2;
                    r_rd      <= w_rd;
                    r_imm     <= w_imm;
                    r_fmt     <= w_fmt;
                    r_illegal <= w_illegal;
                end
            end
        end
    end

    assign decode_valid_o   = r_valid;
    assign decode_pc_o      = r_pc;
    assign decode_pc_next_o = r_pc_next;
    assign decode_ir_o      = r_ir;
    assign decode_rs1_o     = r_rs1;
    assign decode_rs2_o     = r_rs2;
    assign decode_rd_o      = r_rd;
    assign decode_imm_o     = r_imm;
    assign decode_fmt_o     = r_fmt;
    assign decode_illegal_o = r_illegal;
    assign decode_count_o   = r_count;

endmodule

// File: tb/tb_stage_decode.sv
// Directed self-checking bench for stage_decode; expectations adapt to DECODE_SKID_BUFFER_EN.
module tb_stage_decode;

    localparam logic [31:0] RV = 32'h0000_1000;
`ifdef DECODE_SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc, fetch_ir, fetch_pc_next;
    logic        fetch_valid, fetch_ready, flush;
    logic [31:0] d_pc, d_pc_next, d_ir, d_imm, d_count;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [2:0]  d_fmt;
    logic        d_illegal, d_valid, d_ready;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    stage_decode #(.RESET_VECTOR(RV)) dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_pc_i(fetch_pc), .fetch_ir_i(fetch_ir), .fetch_pc_next_i(fetch_pc_next),
        .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready), .flush_i(flush),
        .decode_pc_o(d_pc), .decode_pc_next_o(d_pc_next), .decode_ir_o(d_ir),
        .decode_rs1_o(d_rs1), .decode_rs2_o(d_rs2), .decode_rd_o(d_rd),
        .decode_imm_o(d_imm), .decode_fmt_o(d_fmt), .decode_illegal_o(d_illegal),
        .decode_valid_o(d_valid), .decode_ready_i(d_ready), .decode_count_o(d_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] ir);
        fetch_valid   = 1'b1;
        fetch_pc      = pc;
        fetch_ir      = ir;
        fetch_pc_next = pc + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_valid = 1'b0; flush = 1'b0; d_ready = 1'b0;
        fetch_pc = '0; fetch_ir = '0; fetch_pc_next = '0;
        repeat (3) tick();
        n_tests++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", d_valid); end
        n_tests++; if (d_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %h want 0", d_count); end
        n_tests++; if (d_pc !== RV) begin n_fail++; $display("FAIL rst_pc: got %h want %h", d_pc, RV); end
        n_tests++; if (d_pc_next !== RV) begin n_fail++; $display("FAIL rst_pc_next: got %h want %h", d_pc_next, RV); end
        n_tests++; if ({d_ir, d_imm, d_rs1, d_rs2, d_rd, d_fmt, d_illegal} !== '0) begin
            n_fail++; $display("FAIL rst_fields: ir=%h imm=%h fmt=%0d ill=%b want all 0", d_ir, d_imm, d_fmt, d_illegal);
        end
        n_tests++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL rst_fready: got %b want 0", fetch_ready); end
        rst = 1'b0;
        tick();
        n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_fready: got %b want 1", fetch_ready); end
    endtask

    task automatic test_addi();
        d_ready = 1'b1;
        offer(32'h100, 32'h0050_0093);
        tick();
        fetch_valid = 1'b0;
        n_tests++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", d_valid); end
        n_tests++; if (d_fmt !== 3'd1) begin n_fail++; $display("FAIL addi_fmt: got %0d want 1", d_fmt); end
        n_tests++; if ({d_rd, d_rs1, d_rs2} !== {5'd1, 5'd0, 5'd0}) begin
            n_fail++; $display("FAIL addi_regs: got rd=%0d rs1=%0d rs2=%0d want 1 0 0", d_rd, d_rs1, d_rs2);
        end
        n_tests++; if (d_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h want 5", d_imm); end
        n_tests++; if (d_pc !== 32'h100 || d_pc_next !== 32'h104) begin
            n_fail++; $display("FAIL addi_pc: got %h/%h want 100/104", d_pc, d_pc_next);
        end
        tick();
        n_tests++; if (d_count !== 32'd1) begin n_fail++; $display("FAIL addi_count: got %0d want 1", d_count); end
        n_tests++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", d_valid); end
    endtask

    task automatic test_back_to_back();
        d_ready = 1'b1;
        offer(32'h104, 32'h0020_A423);
        tick();
        offer(32'h108, 32'hFFDF_F0EF);
        n_tests++; if ({d_fmt, d_rs1, d_rs2, d_rd} !== {3'd2, 5'd1, 5'd2, 5'd0}) begin
            n_fail++; $display("FAIL sw_fields: got fmt=%0d rs1=%0d rs2=%0d rd=%0d want 2 1 2 0", d_fmt, d_rs1, d_rs2, d_rd);
        end
        n_tests++; if (d_imm !== 32'd8) begin n_fail++; $display("FAIL sw_imm: got %h want 8", d_imm); end
        tick();
        fetch_valid = 1'b0;
        n_tests++; if ({d_fmt, d_rd, d_rs1, d_rs2} !== {3'd5, 5'd1, 5'd0, 5'd0}) begin
            n_fail++; $display("FAIL jal_fields: got fmt=%0d rd=%0d rs1=%0d rs2=%0d want 5 1 0 0", d_fmt, d_rd, d_rs1, d_rs2);
        end
        n_tests++; if (d_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL jal_imm: got %h want fffffffc", d_imm); end
        n_tests++; if (d_count !== 32'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", d_count); end
        tick();
        n_tests++; if (d_count !== 32'd3) begin n_fail++; $display("FAIL b2b_count_drain: got %0d want 3", d_count); end
    endtask

    task automatic test_illegal();
        d_ready = 1'b1;
        offer(32'h200, 32'h0000_007F);
        tick();
        offer(32'h204, 32'h0000_0000);
        n_tests++; if ({d_illegal, d_fmt, d_imm, d_rs1, d_rs2, d_rd} !== {1'b1, 3'd7, 32'd0, 15'd0}) begin
            n_fail++; $display("FAIL ill7f: got ill=%b fmt=%0d imm=%h rs1=%0d rs2=%0d rd=%0d want 1 7 0 0 0 0",
                               d_illegal, d_fmt, d_imm, d_rs1, d_rs2, d_rd);
        end
        tick();
        fetch_valid = 1'b0;
        n_tests++; if ({d_illegal, d_fmt, d_imm, d_rs1, d_rs2, d_rd} !== {1'b1, 3'd7, 32'd0, 15'd0} || d_pc !== 32'h204) begin
            n_fail++; $display("FAIL ill00: got ill=%b fmt=%0d imm=%h pc=%h want 1 7 0 pc=204", d_illegal, d_fmt, d_imm, d_pc);
        end
        tick();
        n_tests++; if (d_count !== 32'd5) begin n_fail++; $display("FAIL ill_count: got %0d want 5", d_count); end
    endtask

    task automatic test_reset_mid();
        d_ready = 1'b1;
        offer(32'h300, 32'h0010_0193); tick();
        offer(32'h304, 32'h0020_0213); tick();
        offer(32'h308, 32'h0030_0293); tick();
        offer(32'h30C, 32'h0040_0313);
        n_tests++; if (d_count !== 32'd7 || d_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got count=%0d valid=%b want 7 1", d_count, d_valid);
        end
        #2;
        rst = 1'b1;
        fetch_valid = 1'b0;
        #1;
        n_tests++; if (d_valid !== 1'b0 || d_count !== 32'd0) begin
            n_fail++; $display("FAIL mid_async: got valid=%b count=%0d want 0 0", d_valid, d_count);
        end
        n_tests++; if (d_pc !== RV || d_pc_next !== RV || d_ir !== 32'd0) begin
            n_fail++; $display("FAIL mid_fields: got pc=%h pcn=%h ir=%h want %h %h 0", d_pc, d_pc_next, d_ir, RV, RV);
        end
        tick();
        n_tests++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL mid_fready_rst: got %b want 0", fetch_ready); end
        rst = 1'b0;
        tick();
        n_tests++; if (fetch_ready !== 1'b1 || d_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: got fready=%b valid=%b want 1 0", fetch_ready, d_valid);
        end
        offer(32'h400, 32'h0050_0093);
        tick();
        fetch_valid = 1'b0;
        n_tests++; if (d_valid !== 1'b1 || d_pc !== 32'h400 || d_count !== 32'd0) begin
            n_fail++; $display("FAIL mid_first: got valid=%b pc=%h count=%0d want 1 400 0", d_valid, d_pc, d_count);
        end
        tick();
        n_tests++; if (d_count !== 32'd1) begin n_fail++; $display("FAIL mid_count: got %0d want 1", d_count); end
    endtask

    task automatic test_stall();
        logic [31:0] irs  [3] = '{32'h0010_0193, 32'h0020_0213, 32'h0030_0293};
        logic [31:0] seen [3] = '{32'd0, 32'd0, 32'd0};
        int unsigned sent = 0;
        int unsigned got  = 0;
        int unsigned early = 0;
        d_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (sent < 3) offer(32'h500 + 32'(sent * 4), irs[sent]);
            else fetch_valid = 1'b0;
            #1;
            if (c == 1) begin
                n_tests++; if (fetch_ready !== SKID) begin
                    n_fail++; $display("FAIL stall_fready_c1: got %b want %b", fetch_ready, SKID);
                end
            end
            if (c == 2) begin
                n_tests++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL stall_fready_c2: got %b want 0", fetch_ready); end
            end
            if (c >= 1) begin
                n_tests++; if (d_valid !== 1'b1 || d_ir !== irs[0] || d_pc !== 32'h500 || d_rd !== 5'd3) begin
                    n_fail++; $display("FAIL stall_frozen%0d: got valid=%b ir=%h pc=%h rd=%0d want 1 %h 500 3",
                                       c, d_valid, d_ir, d_pc, d_rd, irs[0]);
                end
            end
            if (d_valid && d_ready) early++;
            if (fetch_valid && fetch_ready) sent++;
            tick();
        end
        n_tests++; if (sent !== (SKID ? 32'd2 : 32'd1)) begin
            n_fail++; $display("FAIL stall_accepted: got %0d want %0d", sent, SKID ? 2 : 1);
        end
        n_tests++; if (early !== 0 || d_count !== 32'd1) begin
            n_fail++; $display("FAIL stall_no_xfer: got xfers=%0d count=%0d want 0 1", early, d_count);
        end
        d_ready = 1'b1;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (sent < 3) offer(32'h500 + 32'(sent * 4), irs[sent]);
            else fetch_valid = 1'b0;
            #1;
            if (d_valid && d_ready) begin
                seen[got] = d_ir;
                got++;
            end
            if (fetch_valid && fetch_ready) sent++;
            tick();
        end
        fetch_valid = 1'b0;
        n_tests++; if (got !== 3) begin n_fail++; $display("FAIL stall_drain_timeout: got %0d want 3", got); end
        n_tests++; if (seen[0] !== irs[0] || seen[1] !== irs[1] || seen[2] !== irs[2]) begin
            n_fail++; $display("FAIL stall_order: got %h %h %h want %h %h %h", seen[0], seen[1], seen[2], irs[0], irs[1], irs[2]);
        end
        n_tests++; if (d_count !== 32'd4 || d_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_count: got count=%0d valid=%b want 4 0", d_count, d_valid);
        end
    endtask

    task automatic test_flush();
        d_ready = 1'b1;
        offer(32'h600, 32'h0050_0093);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fetch_valid = 1'b0;
        n_tests++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got valid=%b want 0", d_valid); end
        d_ready = 1'b0;
        offer(32'h700, 32'h0010_0193); tick();
        offer(32'h704, 32'h0020_0213); tick();
        offer(32'h708, 32'h0030_0293);
        n_tests++; if (d_valid !== 1'b1 || fetch_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_pre: got valid=%b fready=%b want 1 0", d_valid, fetch_ready);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fetch_valid = 1'b0;
        n_tests++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", d_valid); end
        n_tests++; if (d_count !== 32'd4) begin n_fail++; $display("FAIL flush_count: got %0d want 4", d_count); end
        n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL flush_fready: got %b want 1", fetch_ready); end
        d_ready = 1'b1;
        repeat (3) tick();
        n_tests++; if (d_valid !== 1'b0 || d_count !== 32'd4) begin
            n_fail++; $display("FAIL flush_skid_cleared: got valid=%b count=%0d want 0 4", d_valid, d_count);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_stall();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
